// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC register plus F/D pipeline register with
// stall, exception-entry and eret redirects. Define FETCH_ADEL_EN for fetch AdEL detection.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        npc_is_branch,
  input  logic        stall,
  input  logic        req_exc,
  input  logic        req_eret,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic        bd_D,
  output logic [4:0]  exc_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        bd_d;
  logic [4:0]  exc_d;
  logic [4:0]  exc_f;

`ifdef FETCH_ADEL_EN
  // A fetch outside the instruction window or off a word boundary raises AdEL.
  assign exc_f = ((pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_LIMIT))
                 ? EXC_ADEL : EXC_NONE;
`else
  assign exc_f = EXC_NONE;
`endif

  assign im_addr = pc_f;
  assign PC_F    = pc_f;
  assign instr_D = instr_d;
  assign PC_D    = pc_d;
  assign bd_D    = bd_d;
  assign exc_D   = exc_d;

  // Exception entry beats stall; a stalled eret stays in D and retries later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f    <= RESET_PC;
      instr_d <= '0;
      pc_d    <= '0;
      bd_d    <= 1'b0;
      exc_d   <= EXC_NONE;
    end else if (req_exc) begin
      pc_f    <= HANDLER_PC;
      instr_d <= '0;
      pc_d    <= '0;
      bd_d    <= 1'b0;
      exc_d   <= EXC_NONE;
    end else if (stall) begin
      pc_f    <= pc_f;
      instr_d <= instr_d;
      pc_d    <= pc_d;
      bd_d    <= bd_d;
      exc_d   <= exc_d;
    end else if (req_eret) begin
      pc_f    <= epc;
      instr_d <= '0;
      pc_d    <= '0;
      bd_d    <= 1'b0;
      exc_d   <= EXC_NONE;
    end else begin
      pc_f    <= npc;
      instr_d <= (exc_f != EXC_NONE) ? 32'h0 : im_rdata;
      pc_d    <= pc_f;
      bd_d    <= npc_is_branch;
      exc_d   <= exc_f;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a fetch-record model is compared against the
// DUT on every negative clock edge, plus hand-computed literal checks.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        npc_is_branch;
  logic        stall;
  logic        req_exc;
  logic        req_eret;
  logic [31:0] epc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] PC_F;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic        bd_D;
  logic [4:0]  exc_D;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
  } fetch_rec_t;

  logic [31:0] m_pc;
  fetch_rec_t  m_d;

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .npc          (npc),
    .npc_is_branch(npc_is_branch),
    .stall        (stall),
    .req_exc      (req_exc),
    .req_eret     (req_eret),
    .epc          (epc),
    .im_addr      (im_addr),
    .im_rdata     (im_rdata),
    .PC_F         (PC_F),
    .instr_D      (instr_D),
    .PC_D         (PC_D),
    .bd_D         (bd_D),
    .exc_D        (exc_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory returns a word derived from the address so data and PC differ.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic logic [4:0] fetch_exc(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
    if (a[1:0] != 2'b00 || a < 32'h0000_3000 || a > 32'h0000_6FFC) return 5'd4;
`endif
    return 5'd0;
  endfunction

  assign im_rdata = imem(im_addr);

  // Reference model: what sits in D is the record of whatever was fetched last, or a bubble.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= 32'h0000_3000;
      m_d  <= '{32'h0, 32'h0, 1'b0, 5'd0};
    end else if (req_exc) begin
      m_pc <= 32'h0000_4180;
      m_d  <= '{32'h0, 32'h0, 1'b0, 5'd0};
    end else if (!stall && req_eret) begin
      m_pc <= epc;
      m_d  <= '{32'h0, 32'h0, 1'b0, 5'd0};
    end else if (!stall) begin
      m_pc <= npc;
      m_d  <= '{(fetch_exc(m_pc) != 0) ? 32'h0 : imem(m_pc), m_pc, npc_is_branch, fetch_exc(m_pc)};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("pc_f",    PC_F,            m_pc);
    checkOutput("im_addr", im_addr,         m_pc);
    checkOutput("instr_d", instr_D,         m_d.instr);
    checkOutput("pc_d",    PC_D,            m_d.pc);
    checkOutput("bd_d",    {31'h0, bd_D},   {31'h0, m_d.bd});
    checkOutput("exc_d",   {27'h0, exc_D},  {27'h0, m_d.exc});
  end

  task automatic applyStimulus(input logic [31:0] n, input logic br, input logic st,
                               input logic ex, input logic er, input logic [31:0] e);
    npc           = n;
    npc_is_branch = br;
    stall         = st;
    req_exc       = ex;
    req_eret      = er;
    epc           = e;
    @(posedge clk);
    #1;
  endtask

  task automatic stepNext();
    applyStimulus(m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    npc = 32'h0; npc_is_branch = 1'b0; stall = 1'b0;
    req_exc = 1'b0; req_eret = 1'b0; epc = 32'h0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    checkOutput("lit_reset_pc", PC_F, 32'h0000_3000);
    checkOutput("lit_reset_instr", instr_D, 32'h0);

    // Sequential fetch
    stepNext();
    checkOutput("lit_seq1_pc", PC_F, 32'h0000_3004);
    checkOutput("lit_seq1_pcd", PC_D, 32'h0000_3000);
    checkOutput("lit_seq1_instr", instr_D, 32'hFFFF_CFFF);
    stepNext();
    checkOutput("lit_seq2_pc", PC_F, 32'h0000_3008);
    stepNext();
    stepNext();
    checkOutput("lit_at_3010", PC_F, 32'h0000_3010);

    // Stall for three cycles at 0x3010
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0000_3014, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("lit_stall_pc", PC_F, 32'h0000_3010);
      checkOutput("lit_stall_pcd", PC_D, 32'h0000_300C);
    end
    applyStimulus(32'h0000_3014, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_resume_pc", PC_F, 32'h0000_3014);
    checkOutput("lit_resume_pcd", PC_D, 32'h0000_3010);

    // Branch with delay slot
    stepNext(); stepNext(); stepNext();
    applyStimulus(32'h0000_3100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_br_pc", PC_F, 32'h0000_3100);
    checkOutput("lit_br_pcd", PC_D, 32'h0000_3020);
    checkOutput("lit_br_bd", {31'h0, bd_D}, 32'h1);
    stepNext();
    checkOutput("lit_after_br_pcd", PC_D, 32'h0000_3100);
    checkOutput("lit_after_br_bd", {31'h0, bd_D}, 32'h0);

    // Exception beats stall and eret
    applyStimulus(32'h0000_3200, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3040);
    checkOutput("lit_exc_pc", PC_F, 32'h0000_4180);
    checkOutput("lit_exc_pcd", PC_D, 32'h0);
    checkOutput("lit_exc_instr", instr_D, 32'h0);
    stepNext();
    checkOutput("lit_handler_pcd", PC_D, 32'h0000_4180);

    // eret redirect, then eret held by stall
    applyStimulus(32'h0000_4188, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3040);
    checkOutput("lit_eret_pc", PC_F, 32'h0000_3040);
    checkOutput("lit_eret_pcd", PC_D, 32'h0);
    stepNext();
    checkOutput("lit_eret_next_pcd", PC_D, 32'h0000_3040);
    applyStimulus(32'h0000_3048, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3200);
    checkOutput("lit_eret_stall_pc", PC_F, 32'h0000_3044);

    // Back-to-back exceptions
    applyStimulus(32'h0000_3048, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h0000_4184, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lit_b2b_pc", PC_F, 32'h0000_4180);
    checkOutput("lit_b2b_pcd", PC_D, 32'h0);

    // Misaligned and out-of-range fetches
    applyStimulus(32'h0000_3002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h0000_7000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_mis_pcd", PC_D, 32'h0000_3002);
`ifdef FETCH_ADEL_EN
    checkOutput("lit_mis_exc", {27'h0, exc_D}, 32'd4);
    checkOutput("lit_mis_instr", instr_D, 32'h0);
`else
    checkOutput("lit_mis_exc", {27'h0, exc_D}, 32'd0);
    checkOutput("lit_mis_instr", instr_D, 32'hFFFF_CFFD);
`endif
    applyStimulus(32'h0000_3008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_oor_pcd", PC_D, 32'h0000_7000);
    checkOutput("lit_oor_bd", {31'h0, bd_D}, 32'h1);
`ifdef FETCH_ADEL_EN
    checkOutput("lit_oor_exc", {27'h0, exc_D}, 32'd4);
`else
    checkOutput("lit_oor_exc", {27'h0, exc_D}, 32'd0);
`endif

    // Asynchronous reset mid-run, held across a stall
    stepNext();
    stepNext();
    #2 reset = 1'b0;
    #1;
    checkOutput("lit_async_pc", PC_F, 32'h0000_3000);
    checkOutput("lit_async_pcd", PC_D, 32'h0);
    checkOutput("lit_async_instr", instr_D, 32'h0);
    stall = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    applyStimulus(32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_post_reset_pc", PC_F, 32'h0000_3004);
    stepNext();
    stepNext();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
